fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the cpu execute logic.
- Holds a loadable instruction store of ROM_SIZE entries and a program counter.
- Presents one instruction per accepted handshake on a valid/ready output register.
- Supports jump redirects from execute and a program-load port used while the core is stopped.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loadable instruction store, program counter and a valid/ready output register.
// Optional predicate skipping of non-executing instructions is enabled with FETCH_PREDICATE_SKIP_EN.
module fetch_unit #(
    parameter int unsigned ROM_SIZE = 8,
    parameter int unsigned INSTR_W  = 11,
    localparam int unsigned ADDR_W  = $clog2(ROM_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_err,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               flag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic               valid_next;
    logic [INSTR_W-1:0] instr_next;
    logic [ADDR_W-1:0]  out_pc_next;
    logic               load_err_next;
    logic               store_we;
    logic               adv;
    logic               exec;
    logic [INSTR_W-1:0] fetch_word;

    logic [INSTR_W-1:0] store [ROM_SIZE];

`ifndef FETCH_PREDICATE_SKIP_EN
    logic unused_flag;
    assign unused_flag = flag;
`endif

    // Next-state, fetch, redirect and load arbitration
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        valid_next    = out_valid;
        instr_next    = out_instr;
        out_pc_next   = out_pc;
        load_err_next = 1'b0;
        store_we      = 1'b0;
        fetch_word    = store[pc];
        adv           = (state == RUN) && (!out_valid || out_ready);

`ifdef FETCH_PREDICATE_SKIP_EN
        exec = (!fetch_word[INSTR_W-1] || flag) && (!fetch_word[INSTR_W-2] || !flag);
`else
        exec = 1'b1;
`endif

        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A redirect squashes the held instruction even if it is being accepted
        if (jump_valid) begin
            valid_next = 1'b0;
            pc_next    = jump_addr;
        end else if (adv) begin
            pc_next    = pc + ADDR_W'(1);
            valid_next = exec;
            if (exec) begin
                instr_next  = fetch_word;
                out_pc_next = pc;
            end
        end else if (out_valid && out_ready) begin
            valid_next = 1'b0;
        end

        // Loads are only safe while the core is fully stopped
        if (load_en) begin
            if ((state == IDLE) && !enable) begin
                store_we = 1'b1;
            end else begin
                load_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            load_err  <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            out_valid <= valid_next;
            out_instr <= instr_next;
            out_pc    <= out_pc_next;
            load_err  <= load_err_next;
            running   <= (state_next == RUN);
        end
    end

    // Store contents survive reset
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, instr) pairs are queued with stimulus
// and popped on every accepted transfer.
module tb_fetch_unit;

    localparam int unsigned ROM_SIZE = 8;
    localparam int unsigned INSTR_W  = 11;
    localparam int unsigned ADDR_W   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               load_err;
    logic               jump_valid;
    logic [ADDR_W-1:0]  jump_addr;
    logic               flag;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               running;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    fetch_unit #(.ROM_SIZE(ROM_SIZE), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_err   (load_err),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .flag       (flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .running    (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_exp(input int pc, input int instr);
        exp_t e;
        e.pc    = ADDR_W'(pc);
        e.instr = INSTR_W'(instr);
        sb.push_back(e);
    endfunction

    // One clock: score any transfer that the coming edge will complete, then step past the edge
    task automatic cyc();
        exp_t e;
        if (out_valid && out_ready && !jump_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_xfer", 32'(out_pc), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("xfer_pc", 32'(out_pc), 32'(e.pc));
                check("xfer_instr", 32'(out_instr), 32'(e.instr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic load(input int addr, input int data);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = INSTR_W'(data);
        cyc();
        load_en   = 1'b0;
    endtask

    // Stop fetching and squash anything held, leaving the core idle at pc=target
    task automatic stop_and_flush(input int target);
        out_ready  = 1'b0;
        enable     = 1'b0;
        cyc();
        jump_valid = 1'b1;
        jump_addr  = ADDR_W'(target);
        cyc();
        jump_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_running", 32'(running), 32'd0);
    endtask

    task automatic run_pred(input logic f);
        stop_and_flush(0);
        flag = f;
`ifdef FETCH_PREDICATE_SKIP_EN
        push_exp(0, 'h010);
        if (f) push_exp(1, 'h421);
        push_exp(3, 'h013);
        push_exp(4, 'h014);
`else
        push_exp(0, 'h010);
        push_exp(1, 'h421);
        push_exp(2, 'h600);
        push_exp(3, 'h013);
`endif
        enable    = 1'b1;
        out_ready = 1'b1;
        drain(12);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        jump_valid = 1'b0;
        jump_addr  = '0;
        flag       = 1'b0;
        out_ready  = 1'b0;

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Program the store while stopped
        for (int i = 0; i < 8; i++) begin
            load(i, i + 'h10);
            check("idle_load_err", 32'(load_err), 32'd0);
        end

        // Sequential fetch with wrap, and two-edge start latency
        for (int i = 0; i < 9; i++) push_exp(i % 8, (i % 8) + 'h10);
        enable    = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("lat_running", 32'(running), 32'd1);
        check("lat_valid_e1", 32'(out_valid), 32'd0);
        cyc();
        check("lat_valid_e2", 32'(out_valid), 32'd1);
        check("lat_pc_e2", 32'(out_pc), 32'd0);
        drain(9);

        // Back-pressure at pc 3
        push_exp(1, 'h11);
        push_exp(2, 'h12);
        drain(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", 32'(out_pc), 32'd3);
            check("stall_instr", 32'(out_instr), 32'h13);
        end
        push_exp(3, 'h13);
        push_exp(4, 'h14);
        out_ready = 1'b1;
        drain(2);

        // Jump squashes the held pc 2
        for (int i = 5; i < 10; i++) push_exp(i % 8, (i % 8) + 'h10);
        drain(5);
        check("pre_jump_pc", 32'(out_pc), 32'd2);
        jump_valid = 1'b1;
        jump_addr  = 3'd6;
        cyc();
        jump_valid = 1'b0;
        check("jump_squash", 32'(out_valid), 32'd0);
        push_exp(6, 'h16);
        push_exp(7, 'h17);
        push_exp(0, 'h10);
        drain(4);

        // Load while running is rejected
        out_ready = 1'b0;
        load(5, 'h7AA);
        check("run_load_err", 32'(load_err), 32'd1);
        cyc();
        check("load_err_pulse", 32'(load_err), 32'd0);

        // Held instruction stays valid across stop until accepted
        enable = 1'b0;
        cyc();
        check("stop_running", 32'(running), 32'd0);
        check("idle_hold_valid", 32'(out_valid), 32'd1);
        check("idle_hold_pc", 32'(out_pc), 32'd1);
        push_exp(1, 'h11);
        out_ready = 1'b1;
        cyc();
        check("idle_clear_valid", 32'(out_valid), 32'd0);

        // Readback shows the rejected load left store[5] untouched; idle load to 7 takes
        jump_valid = 1'b1;
        jump_addr  = 3'd5;
        cyc();
        jump_valid = 1'b0;
        load(7, 'h155);
        check("idle_load_err7", 32'(load_err), 32'd0);
        push_exp(5, 'h15);
        push_exp(6, 'h16);
        push_exp(7, 'h155);
        enable = 1'b1;
        drain(6);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_pc", 32'(out_pc), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, 'h10);
        push_exp(1, 'h11);
        push_exp(2, 'h12);
        enable    = 1'b1;
        out_ready = 1'b1;
        drain(6);

        // Exec bits: store[1] if_flag, store[2] both bits
        stop_and_flush(0);
        load(1, 'h421);
        load(2, 'h600);
        run_pred(1'b0);
        run_pred(1'b1);
        stop_and_flush(0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
